disp_scan_sched: RTL
====================

// Module: disp_scan_sched
// PURPOSE
//  Scan scheduler for the 8-digit multiplexed 7-segment display.
//  Shares the display between two 32-bit requesters (A, B) via round-robin, frame-synchronous capture.
//  Sequences digit scan with anti-ghost blanking and 16-level PWM brightness.
//  Drives the digit drains directly; feeds nibble/dot/oe to the segment decoder.
// PARAMETERS
//  SLOT       16  clocks per brightness step (ON+OFF window = 16*SLOT clocks)
//  BLANK_CYC  8   clocks all drains off at start of each digit (>=1)
// PORTS
//  CLK         in   1   clock
//  nRST        in   1   reset, synchronous, active low
//  en          in   1   scan enable
//  a_req       in   1   requester A has new frame (level, hold until a_ack)
//  a_data      in   32  A digits, nibble i = digit i
//  a_dots      in   8   A decimal points, bit i = digit i
//  a_ack       out  1   1-clock pulse: A captured
//  b_req/b_data/b_dots/b_ack    same as A, requester B
//  bright      in   4   brightness 0..15
//  drains      out  8   one-hot digit drive, 0 = all off
//  tetrade     out  4   nibble for current digit
//  dot         out  1   dot for current digit
//  seg_oe      out  1   decoder output enable
//  frame_start out  1   1-clock pulse at frame boundary
// BEHAVIOUR
//  All outputs registered. Reset (nRST=0 at posedge): state IDLE, digit idx 0,
//   shadow data/dots 0, rr pointer = B (A wins first tie), all outputs 0.
//  Digit period = BLANK_CYC + 16*SLOT clocks (default 264); frame = 8 digit periods.
//  FSM: IDLE -> BLANK -> ON -> OFF -> BLANK (next digit) ...
//   IDLE: en=0; drains=0, seg_oe=0. en=1 -> BLANK, idx=0, frame boundary.
//   BLANK: BLANK_CYC clocks; drains=0, seg_oe=0; tetrade/dot loaded on entry,
//    stable until next BLANK entry; bright sampled on last BLANK clock.
//   ON: (bright+1)*SLOT clocks; drains[idx]=1, seg_oe=1.
//   OFF: (15-bright)*SLOT clocks; drains=0, seg_oe=0. bright=15 -> OFF skipped,
//    ON goes directly to BLANK.
//   End of digit: idx+1 mod 8; idx wrap 7->0 (and IDLE exit) = frame boundary.
//  Frame boundary (cycle of BLANK entry, idx=0):
//   frame_start=1. If a_req & b_req: grant the one not granted last.
//   If only one: grant it. Granted data/dots copied to shadow, its ack=1 for
//   that cycle, rr pointer updated. No request: shadow kept.
//   tetrade/dot on this cycle take the NEW shadow values.
//  Shadow changes only at frame boundary: no tearing within a frame.
//   Requests arriving mid-frame wait.
//  Requester drops req the clock after ack. req still high next boundary =
//   new request (arbitrated again).
//  tetrade = shadow[4*idx+3 : 4*idx], dot = shadow_dots[idx].
//  en=0 in any state: next clock IDLE; drains=0, seg_oe=0, tetrade/dot=0,
//   idx=0, timer cleared, no acks. Shadow and rr pointer retained.
//  bright changes mid-ON/OFF: no effect until the next digit.
//  Reset mid-frame: as reset; pending reqs served at first boundary after en.
// TESTING
//  reset, en=1, no req -> frame_start at 1st clk; drains 01,02,..,80 each 264 clks; tetrade 0.
//  a_req with data=0x89ABCDEF, dots=0x01 -> a_ack at next boundary;
//   digit0 tetrade=F dot=1, digit7 tetrade=8.
//  a_req & b_req together from reset -> A acked in frame n; B (still req) in frame n+1.
//  bright=0 -> ON 16 clks, OFF 240. bright=15 -> ON 256, no OFF, BLANK 8 between digits.
//  b_data changed + b_req at digit 3 -> digits 3..7 keep old shadow; new data from next frame.
//  en=0 at digit 5 ON -> next clk drains=0 seg_oe=0.
//   en=1 -> frame_start, restart at digit 0, old shadow shown.

Source files
------------

// File: rtl/disp_scan_sched.sv
// rtl/disp_scan_sched.sv - 8-digit 7-segment scan scheduler with A/B frame arbitration and PWM
//
// Scans eight multiplexed digits. Each digit period is BLANK_CYC clocks of
// anti-ghost blanking followed by a 16*SLOT-clock PWM window split into ON and
// OFF by the brightness sampled at the end of blanking. Two requesters share the
// display; a winner is chosen round-robin only at frame boundaries (BLANK entry
// of digit 0), so a frame is never torn.
//
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   en                   scan enable; low forces IDLE with all outputs quiet
//   a_req/a_data/a_dots  requester A frame request (level), digits and dots
//   a_ack                one-clock pulse when A's frame is captured
//   b_req/b_data/b_dots  requester B, same as A
//   b_ack                one-clock pulse when B's frame is captured
//   bright               brightness 0..15
//   drains               one-hot digit drive, 0 = all off
//   tetrade, dot         nibble and decimal point of the current digit
//   seg_oe               segment decoder output enable
//   frame_start          one-clock pulse at each frame boundary
module disp_scan_sched #(
  parameter int SLOT      = 16,
  parameter int BLANK_CYC = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        en,
  input  logic        a_req,
  input  logic [31:0] a_data,
  input  logic [7:0]  a_dots,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [31:0] b_data,
  input  logic [7:0]  b_dots,
  output logic        b_ack,
  input  logic [3:0]  bright,
  output logic [7:0]  drains,
  output logic [3:0]  tetrade,
  output logic        dot,
  output logic        seg_oe,
  output logic        frame_start
);

  localparam int TW = $clog2(16 * SLOT + BLANK_CYC + 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    idx_q;
  logic [3:0]    bright_q;
  logic [31:0]   shadow_q;
  logic [7:0]    dots_q;
  logic          rr_q;          // 1: B was granted last, so A wins the next tie
  logic          a_ack_q, b_ack_q, frame_start_q, seg_oe_q, dot_q;
  logic [7:0]    drains_q;
  logic [3:0]    tetrade_q;

  logic          grant_a_d, grant_b_d, digit_end_d;
  logic [31:0]   shadow_d;
  logic [7:0]    dots_d;
  logic [2:0]    nidx_d;
  logic [TW-1:0] on_last_d, off_last_d;

  always_comb begin
    nidx_d      = idx_q + 3'd1;
    grant_a_d   = a_req & (~b_req | rr_q);
    grant_b_d   = b_req & (~a_req | ~rr_q);
    shadow_d    = shadow_q;
    dots_d      = dots_q;
    if (grant_a_d) begin
      shadow_d = a_data;
      dots_d   = a_dots;
    end else if (grant_b_d) begin
      shadow_d = b_data;
      dots_d   = b_dots;
    end
    on_last_d   = TW'((32'(bright_q) + 32'd1) * SLOT - 1);
    // Unused when bright_q is 15: the OFF phase is skipped entirely.
    off_last_d  = TW'((32'd15 - 32'(bright_q)) * SLOT - 1);
    digit_end_d = (state_q == ON  && timer_q == on_last_d && bright_q == 4'd15) ||
                  (state_q == OFF && timer_q == off_last_d);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      idx_q         <= '0;
      bright_q      <= '0;
      shadow_q      <= '0;
      dots_q        <= '0;
      rr_q          <= 1'b1;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      frame_start_q <= 1'b0;
      seg_oe_q      <= 1'b0;
      drains_q      <= '0;
      tetrade_q     <= '0;
      dot_q         <= 1'b0;
    end else begin
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      frame_start_q <= 1'b0;
      if (!en) begin
        state_q   <= IDLE;
        timer_q   <= '0;
        idx_q     <= '0;
        seg_oe_q  <= 1'b0;
        drains_q  <= '0;
        tetrade_q <= '0;
        dot_q     <= 1'b0;
      end else if (state_q == IDLE || digit_end_d) begin
        state_q  <= BLANK;
        timer_q  <= '0;
        seg_oe_q <= 1'b0;
        drains_q <= '0;
        if (state_q == IDLE || idx_q == 3'd7) begin
          // Frame boundary: capture the winner and show its digit 0 at once.
          idx_q         <= '0;
          frame_start_q <= 1'b1;
          shadow_q      <= shadow_d;
          dots_q        <= dots_d;
          tetrade_q     <= shadow_d[3:0];
          dot_q         <= dots_d[0];
          a_ack_q       <= grant_a_d;
          b_ack_q       <= grant_b_d;
          if (grant_a_d)      rr_q <= 1'b0;
          else if (grant_b_d) rr_q <= 1'b1;
        end else begin
          idx_q     <= nidx_d;
          tetrade_q <= shadow_q[{nidx_d, 2'b00} +: 4];
          dot_q     <= dots_q[nidx_d];
        end
      end else begin
        case (state_q)
          BLANK: begin
            if (timer_q == BLANK_LAST) begin
              state_q  <= ON;
              timer_q  <= '0;
              bright_q <= bright;
              drains_q <= 8'b1 << idx_q;
              seg_oe_q <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          ON: begin
            if (timer_q == on_last_d) begin
              state_q  <= OFF;
              timer_q  <= '0;
              drains_q <= '0;
              seg_oe_q <= 1'b0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          OFF:     timer_q <= timer_q + 1'b1;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign frame_start = frame_start_q;
  assign seg_oe      = seg_oe_q;
  assign drains      = drains_q;
  assign tetrade     = tetrade_q;
  assign dot         = dot_q;

endmodule
